// File: rtl/opb_reg_bank_pkg.sv
// Shared offsets, bit positions and word type for the OPB snapshot register bank.
// Bit indices are little-endian positions within a 32-bit word (OPB bit 31 == index 0).
package opb_reg_bank_pkg;

   localparam int SEQ_W = 16;

   typedef logic [31:0] word_t;

   localparam word_t OFS_CTRL   = 32'h0000_0000;
   localparam word_t OFS_STATUS = 32'h0000_0004;
   localparam word_t OFS_CH0    = 32'h0000_0010;

   localparam int SNAP_BIT  = 0;
   localparam int VALID_BIT = 0;
   localparam int ARMED_BIT = 1;

   // seq lives in the upper half (OPB bits 0..15).
   function automatic word_t status_word(input logic [SEQ_W-1:0] seq,
                                         input logic armed,
                                         input logic valid);
      word_t w;
      w = '0;
      w[31:32-SEQ_W] = seq;
      w[ARMED_BIT]   = armed;
      w[VALID_BIT]   = valid;
      return w;
   endfunction

endpackage

// File: rtl/opb_slave_ack.sv
// OPB slave front end: window decode, single-cycle registered ack and read data
// that is forced to zero whenever no ack is being driven.
module opb_slave_ack
   import opb_reg_bank_pkg::*;
#(
   parameter logic [31:0] C_BASEADDR = 32'h0100_0600,
   parameter logic [31:0] C_HIGHADDR = 32'h0100_06FF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] abus,
   input  logic        select,
   input  logic [31:0] rd_data,
   output logic        hit,
   output logic        xfer_ack,
   output logic [31:0] dbus
);

   // Handshake: a hit is select inside the window while no ack is out; the ack
   // follows one cycle later for exactly one cycle, so back-to-back transfers
   // complete at most every other cycle. There is no retry or error response.
   logic        ack_q;
   logic [31:0] rd_q;

   assign hit      = select && (abus >= C_BASEADDR) && (abus <= C_HIGHADDR) && !ack_q;
   assign xfer_ack = ack_q;
   assign dbus     = ack_q ? rd_q : 32'h0;

   always_ff @(posedge clk) begin
      if (rst) begin
         ack_q <= 1'b0;
         rd_q  <= '0;
      end else begin
         ack_q <= hit;
         if (hit) rd_q <= rd_data;
      end
   end

endmodule

// File: rtl/opb_register_bank_simulink2ppc.sv
// Multi-channel snapshot register bank on OPB with CTRL/STATUS words and a sequence counter.
// Define OPB_REG_BANK_ARM_EN to make a CTRL write arm the capture, which then waits for user_valid.
module opb_register_bank_simulink2ppc
   import opb_reg_bank_pkg::*;
#(
   parameter logic [31:0] C_BASEADDR   = 32'h0100_0600,
   parameter logic [31:0] C_HIGHADDR   = 32'h0100_06FF,
   parameter int          C_OPB_AWIDTH = 32,
   parameter int          C_OPB_DWIDTH = 32,
   parameter int          C_NUM_CH     = 4,
   parameter              C_FAMILY     = "virtex5"
) (
   input  logic                    OPB_Clk,
   input  logic                    OPB_Rst,
   input  logic [0:31]             OPB_ABus,
   input  logic [0:3]              OPB_BE,
   input  logic [0:31]             OPB_DBus,
   input  logic                    OPB_RNW,
   input  logic                    OPB_select,
   input  logic                    OPB_seqAddr,
   output logic [0:31]             Sl_DBus,
   output logic                    Sl_xferAck,
   output logic                    Sl_errAck,
   output logic                    Sl_retry,
   output logic                    Sl_toutSup,
   input  logic [32*C_NUM_CH-1:0]  user_data_in,
   input  logic                    user_valid,
   output logic                    snap_pulse
);

   logic [31:0]      abus_w;
   logic [31:0]      dbus_w;
   logic [31:0]      ofs;
   logic [31:0]      ofs_al;
   logic [31:0]      rd_data;
   logic [31:0]      sl_dbus_w;
   logic             hit;
   logic             wr_ctrl_hit;
   logic             wr_ctrl_q;
   logic             capture;
   logic             armed_q;
   logic             valid_q;
   logic [SEQ_W-1:0] seq_q;
   logic [31:0]      bank_q [C_NUM_CH];

   assign abus_w = OPB_ABus;
   assign dbus_w = OPB_DBus;
   assign ofs    = abus_w - C_BASEADDR;
   assign ofs_al = {ofs[31:2], 2'b00};

   assign Sl_errAck  = 1'b0;
   assign Sl_retry   = 1'b0;
   assign Sl_toutSup = 1'b0;
   assign Sl_DBus    = sl_dbus_w;
   assign snap_pulse = capture;

   opb_slave_ack #(
      .C_BASEADDR (C_BASEADDR),
      .C_HIGHADDR (C_HIGHADDR)
   ) u_ack (
      .clk      (OPB_Clk),
      .rst      (OPB_Rst),
      .abus     (abus_w),
      .select   (OPB_select),
      .rd_data  (rd_data),
      .hit      (hit),
      .xfer_ack (Sl_xferAck),
      .dbus     (sl_dbus_w)
   );

   always_comb begin
      rd_data = '0;
      if (OPB_RNW) begin
         if (ofs_al == OFS_STATUS) rd_data = status_word(seq_q, armed_q, valid_q);
         for (int i = 0; i < C_NUM_CH; i++) begin
            if (ofs_al == OFS_CH0 + 32'(4 * i)) rd_data = bank_q[i];
         end
      end
   end

   assign wr_ctrl_hit = hit && !OPB_RNW && (ofs_al == OFS_CTRL) && OPB_BE[3] && dbus_w[SNAP_BIT];

   // wr_ctrl_q is high exactly in the ack cycle of a snapshot request.
   always_ff @(posedge OPB_Clk) begin
      if (OPB_Rst) wr_ctrl_q <= 1'b0;
      else         wr_ctrl_q <= wr_ctrl_hit;
   end

`ifdef OPB_REG_BANK_ARM_EN
   // Arming only takes effect after the write's ack cycle, so capture cannot coincide with it.
   always_ff @(posedge OPB_Clk) begin
      if (OPB_Rst)        armed_q <= 1'b0;
      else if (wr_ctrl_q) armed_q <= 1'b1;
      else if (capture)   armed_q <= 1'b0;
   end
   assign capture = armed_q && user_valid;
`else
   logic snap_req_q;
   always_ff @(posedge OPB_Clk) begin
      if (OPB_Rst) snap_req_q <= 1'b0;
      else         snap_req_q <= wr_ctrl_q;
   end
   assign armed_q = 1'b0;
   assign capture = snap_req_q;
`endif

   always_ff @(posedge OPB_Clk) begin
      if (OPB_Rst) begin
         seq_q   <= '0;
         valid_q <= 1'b0;
         for (int i = 0; i < C_NUM_CH; i++) bank_q[i] <= '0;
      end else begin
         seq_q   <= seq_q + SEQ_W'(capture);
         valid_q <= valid_q | capture;
         if (capture) begin
            for (int i = 0; i < C_NUM_CH; i++) bank_q[i] <= user_data_in[32*i +: 32];
         end
      end
   end

   logic unused_ok;
   assign unused_ok = ^{OPB_seqAddr, user_valid, OPB_BE[0:2], dbus_w[31:1], ofs[1:0],
                        C_OPB_AWIDTH[0], C_OPB_DWIDTH[0], C_FAMILY[0]};

endmodule

// File: tb/tb_opb_register_bank_simulink2ppc.sv
// Directed bench for the OPB snapshot register bank: map, handshake, snapshot, seq wrap, reset.
// Covers both builds; the armed-capture path is exercised when OPB_REG_BANK_ARM_EN is defined.
module tb_opb_register_bank_simulink2ppc;

   localparam logic [31:0] BASE = 32'h0100_0600;

   logic         clk;
   logic         rst;
   logic [0:31]  abus;
   logic [0:3]   be;
   logic [0:31]  wdata;
   logic         rnw;
   logic         sel;
   logic         seq_addr;
   logic [0:31]  sl_dbus;
   logic         sl_ack;
   logic         sl_err;
   logic         sl_retry;
   logic         sl_tout;
   logic [127:0] user_data;
   logic         user_valid;
   logic         snap_pulse;

   int           n_checks;
   int           n_fail;
   logic [31:0]  exp_q[$];
   logic [15:0]  exp_seq;
   logic         exp_valid;

   opb_register_bank_simulink2ppc dut (
      .OPB_Clk      (clk),
      .OPB_Rst      (rst),
      .OPB_ABus     (abus),
      .OPB_BE       (be),
      .OPB_DBus     (wdata),
      .OPB_RNW      (rnw),
      .OPB_select   (sel),
      .OPB_seqAddr  (seq_addr),
      .Sl_DBus      (sl_dbus),
      .Sl_xferAck   (sl_ack),
      .Sl_errAck    (sl_err),
      .Sl_retry     (sl_retry),
      .Sl_toutSup   (sl_tout),
      .user_data_in (user_data),
      .user_valid   (user_valid),
      .snap_pulse   (snap_pulse)
   );

   // clock / watchdog
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] status_exp(input logic [15:0] seq, input logic armed,
                                              input logic valid);
      return {seq, 14'b0, armed, valid};
   endfunction

   // driver tasks
   task automatic bus_idle();
      sel   = 1'b0;
      rnw   = 1'b1;
      abus  = '0;
      be    = '0;
      wdata = '0;
   endtask

   task automatic opb_xfer(input logic [31:0] addr, input logic is_rd, input logic [31:0] d,
                           input logic [3:0] b, output logic [31:0] rdata, output int lat);
      @(posedge clk); #1;
      abus  = addr;
      rnw   = is_rd;
      wdata = d;
      be    = b;
      sel   = 1'b1;
      lat   = -1;
      rdata = 32'hxxxx_xxxx;
      for (int c = 1; c <= 8; c++) begin
         @(posedge clk); #1;
         if (sl_ack) begin
            lat   = c;
            rdata = sl_dbus;
            break;
         end
      end
      bus_idle();
   endtask

   task automatic rd_check(input logic [31:0] addr, input string tag, input logic [31:0] exp);
      logic [31:0] rd;
      int          lat;
      exp_q.push_back(exp);
      opb_xfer(addr, 1'b1, 32'h0, 4'h0, rd, lat);
      check({tag, "_lat"}, lat, 1);
      check(tag, rd, exp_q.pop_front());
   endtask

   // Returns snap_pulse as seen in the cycle right after the ack.
   task automatic wr(input logic [31:0] addr, input logic [31:0] d, input logic [3:0] b,
                     input string tag, output logic snap_seen);
      logic [31:0] rd;
      int          lat;
      opb_xfer(addr, 1'b0, d, b, rd, lat);
      check({tag, "_lat"}, lat, 1);
      @(posedge clk); #1;
      snap_seen = snap_pulse;
   endtask

   task automatic take_snapshot(input string tag);
      logic s;
      wr(BASE, 32'h0000_0001, 4'hF, tag, s);
`ifdef OPB_REG_BANK_ARM_EN
      check({tag, "_no_snap_on_arm"}, s, 0);
      rd_check(BASE + 32'h4, {tag, "_armed"}, status_exp(exp_seq, 1'b1, exp_valid));
      for (int c = 0; c < 10; c++) begin
         @(posedge clk); #1;
         check({tag, "_hold"}, snap_pulse, 0);
      end
      user_valid = 1'b1;
      #1;
      check({tag, "_snap_on_valid"}, snap_pulse, 1);
      @(posedge clk); #1;
      user_valid = 1'b0;
      check({tag, "_snap_once"}, snap_pulse, 0);
`else
      check({tag, "_snap"}, s, 1);
      @(posedge clk); #1;
      check({tag, "_snap_once"}, snap_pulse, 0);
`endif
      exp_seq   = exp_seq + 16'd1;
      exp_valid = 1'b1;
   endtask

   task automatic read_channels(input logic [127:0] pat, input string tag);
      for (int i = 0; i < 4; i++)
         rd_check(BASE + 32'h10 + 32'(4 * i), $sformatf("%s_ch%0d", tag, i), pat[32*i +: 32]);
   endtask

   initial begin
      logic [127:0] pat;
      logic [31:0]  rd;
      logic         s;
      int           lat;
      int           acks;

      n_checks   = 0;
      n_fail     = 0;
      exp_seq    = 16'h0;
      exp_valid  = 1'b0;
      seq_addr   = 1'b0;
      user_valid = 1'b0;
      user_data  = '0;
      bus_idle();

      // reset
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("rst_ack", sl_ack, 0);
      check("rst_dbus", sl_dbus, 0);
      check("rst_snap", snap_pulse, 0);
      check("const_outs", {sl_err, sl_retry, sl_tout}, 0);
      rst = 1'b0;

      // 1: STATUS after reset, single ack
      rd_check(BASE + 32'h4, "status_rst", 32'h0);
      acks = 0;
      for (int c = 0; c < 4; c++) begin
         @(posedge clk); #1;
         acks += int'(sl_ack);
         check("idle_dbus", sl_dbus, 0);
      end
      check("no_extra_ack", acks, 0);

      // 2: capture then change inputs
      pat = {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
      user_data = pat;
      take_snapshot("snap1");
      user_data = {$urandom, $urandom, $urandom, $urandom};
      read_channels(pat, "snap1");
      rd_check(BASE + 32'h4, "status1", status_exp(16'h0001, 1'b0, 1'b1));
      rd_check(BASE, "ctrl_reads_0", 32'h0);
      wr(BASE + 32'h14, 32'hDEAD_BEEF, 4'hF, "wr_ro", s);
      check("wr_ro_snap", s, 0);
      rd_check(BASE + 32'h14, "ro_kept", 32'h2222_2222);

      // 4: ignored CTRL writes, holes, out of window
      wr(BASE, 32'h0000_0001, 4'b1110, "ctrl_be", s);
      check("ctrl_be_snap", s, 0);
      wr(BASE, 32'hFFFF_FFFE, 4'hF, "ctrl_d0", s);
      check("ctrl_d0_snap", s, 0);
      rd_check(BASE + 32'h4, "status_unch", status_exp(exp_seq, 1'b0, 1'b1));
      rd_check(BASE + 32'h30, "hole", 32'h0);
      opb_xfer(32'h0100_0700, 1'b1, 32'h0, 4'h0, rd, lat);
      check("above_win", lat, -1);
      opb_xfer(32'h0100_05FC, 1'b0, 32'h1, 4'hF, rd, lat);
      check("below_win", lat, -1);

      // user_valid alone never captures
      user_valid = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(posedge clk); #1;
         check("uv_no_snap", snap_pulse, 0);
      end
      user_valid = 1'b0;

      // 3: seq wrap (preload seq as if 0xFFFF snapshots had been taken)
      @(posedge clk); #1;
      force dut.seq_q = 16'hFFFF;
      @(posedge clk); #1;
      release dut.seq_q;
      exp_seq = 16'hFFFF;
      rd_check(BASE + 32'h4, "status_ffff", status_exp(16'hFFFF, 1'b0, 1'b1));
      pat = {32'hA5A5_0003, 32'h5A5A_0002, 32'h0F0F_0001, 32'hF0F0_0000};
      user_data = pat;
      take_snapshot("snap_wrap");
      user_data = '0;
      rd_check(BASE + 32'h4, "status_wrap", status_exp(16'h0000, 1'b0, 1'b1));
      read_channels(pat, "snap_wrap");

      // 6: reset between hit and ack
      @(posedge clk); #1;
      abus = BASE + 32'h4;
      rnw  = 1'b1;
      sel  = 1'b1;
      rst  = 1'b1;
      @(posedge clk); #1;
      check("rst_mid_ack", sl_ack, 0);
      bus_idle();
      rst = 1'b0;
      acks = 0;
      for (int c = 0; c < 3; c++) begin
         @(posedge clk); #1;
         acks += int'(sl_ack);
      end
      check("rst_mid_no_late_ack", acks, 0);
      exp_seq   = 16'h0;
      exp_valid = 1'b0;
      rd_check(BASE + 32'h4, "status_after_rst", 32'h0);
      read_channels(128'h0, "after_rst");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
